// File: rtl/apb_pkg.sv
// Shared definitions for the APB register slave: FSM encoding, register map
// indices and the field widths used by the decode and status logic.
package apb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_ABORT  = 2'd2
    } apb_state_e;

    localparam int IDX_W         = 4;
    localparam int ERR_W         = 8;
    localparam int WAIT_W        = 4;
    localparam int NUM_DATA_REGS = 14;

    localparam logic [IDX_W-1:0] IDX_STATUS = 4'd14;
    localparam logic [IDX_W-1:0] IDX_ID     = 4'd15;

    // Misaligned, out-of-window, or a write to the read-only ID register.
    function automatic logic addr_error(input logic [31:0] addr, input logic write);
        return (addr[1:0] != 2'b00) || (addr[31:6] != '0) ||
               (write && (addr[5:2] == IDX_ID));
    endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// Wait-state down-counter: loaded at setup, stepped once per stalled access
// cycle, and reports when the access may complete.
module apb_wait_timer
    import apb_pkg::*;
(
    input  logic              Hclk,
    input  logic              Hreset,
    input  logic              load,
    input  logic [WAIT_W-1:0] load_value,
    input  logic              dec,
    output logic              zero
);

    logic [WAIT_W-1:0] count;

    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/apb_slave_regs.sv
// APB completer with fourteen data registers, a protocol-error STATUS counter
// and a read-only ID register, with a programmable number of wait states.
module apb_slave_regs
    import apb_pkg::*;
#(
    parameter int          WAIT_CYCLES = 1,
    parameter logic [31:0] ID_VALUE    = 32'hA5B0_0001
) (
    input  logic        Hclk,
    input  logic        Hreset,
    input  logic        Psel,
    input  logic        Penable,
    input  logic        Pwrite,
    input  logic [31:0] Paddr,
    input  logic [31:0] PWdata,
    output logic [31:0] PRdata,
    output logic        Pready,
    output logic        Pslverr
);

    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(WAIT_CYCLES);

    apb_state_e state, next_state;

    logic [31:0]      cap_addr;
    logic [31:0]      cap_wdata;
    logic             cap_write;
    logic [IDX_W-1:0] cap_idx;
    logic             cap_err;

    logic [31:0]      data_regs [NUM_DATA_REGS];
    logic [ERR_W-1:0] err_count;
    logic [31:0]      read_value;

    logic setup;
    logic access_active;
    logic timer_zero;
    logic timer_dec;
    logic commit;
    logic enter_abort;

    assign setup         = (state == ST_IDLE) && Psel && !Penable;
    assign access_active = (state == ST_ACCESS) && Psel && Penable;
    assign timer_dec     = access_active && !timer_zero;
    assign cap_idx       = cap_addr[5:2];
    assign cap_err       = addr_error(cap_addr, cap_write);
    assign commit        = Pready && cap_write && !cap_err;
    assign enter_abort   = (state != ST_ABORT) && (next_state == ST_ABORT);

    apb_wait_timer u_wait_timer (
        .Hclk       (Hclk),
        .Hreset     (Hreset),
        .load       (setup),
        .load_value (WAIT_LOAD),
        .dec        (timer_dec),
        .zero       (timer_zero)
    );

    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (Penable) begin
                    next_state = ST_ABORT;
                end else if (Psel) begin
                    next_state = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (!Psel) begin
                    next_state = ST_IDLE;
                end else if (!Penable) begin
                    next_state = ST_ABORT;
                end else if (timer_zero) begin
                    next_state = ST_IDLE;
                end
            end
            ST_ABORT: begin
                if (!Psel || !Penable) begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        Pready  = access_active && timer_zero;
        Pslverr = Pready && cap_err;
        PRdata  = '0;
        if (Pready && !cap_write && !cap_err) begin
            PRdata = read_value;
        end
    end

    always_comb begin
        read_value = '0;
        if (cap_idx == IDX_ID) begin
            read_value = ID_VALUE;
        end else if (cap_idx == IDX_STATUS) begin
            read_value = {{(32-ERR_W){1'b0}}, err_count};
        end else begin
            read_value = data_regs[cap_idx];
        end
    end

    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            cap_addr  <= '0;
            cap_wdata <= '0;
            cap_write <= 1'b0;
        end else if (setup) begin
            cap_addr  <= Paddr;
            cap_wdata <= PWdata;
            cap_write <= Pwrite;
        end
    end

    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            for (int i = 0; i < NUM_DATA_REGS; i++) begin
                data_regs[i] <= '0;
            end
        end else if (commit && (cap_idx < IDX_STATUS)) begin
            data_regs[cap_idx] <= cap_wdata;
        end
    end

    // A STATUS write in the same cycle as a new protocol error clears the count.
    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            err_count <= '0;
        end else if (commit && (cap_idx == IDX_STATUS)) begin
            err_count <= '0;
        end else if (enter_abort && (err_count != '1)) begin
            err_count <= err_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_apb_slave_regs.sv
// Scoreboard bench for apb_slave_regs: one instance with one wait state and
// one with zero wait states, selected through a shared bus.
module tb_apb_slave_regs;

    logic        Hclk = 1'b0;
    logic        Hreset;
    logic        psel, penable, pwrite;
    logic [31:0] paddr, pwdata;
    int          tgt;

    logic        psel1, penable1, psel0, penable0;
    logic [31:0] prdata1, prdata0, prdata;
    logic        pready1, pready0, pready;
    logic        pslverr1, pslverr0, pslverr;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          latency;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   compared   = 0;
    int   mismatched = 0;

    always #5 Hclk = ~Hclk;

    assign psel1    = psel && (tgt == 1);
    assign penable1 = penable && (tgt == 1);
    assign psel0    = psel && (tgt == 0);
    assign penable0 = penable && (tgt == 0);
    assign prdata   = (tgt == 1) ? prdata1  : prdata0;
    assign pready   = (tgt == 1) ? pready1  : pready0;
    assign pslverr  = (tgt == 1) ? pslverr1 : pslverr0;

    apb_slave_regs #(.WAIT_CYCLES(1)) dut1 (
        .Hclk    (Hclk),
        .Hreset  (Hreset),
        .Psel    (psel1),
        .Penable (penable1),
        .Pwrite  (pwrite),
        .Paddr   (paddr),
        .PWdata  (pwdata),
        .PRdata  (prdata1),
        .Pready  (pready1),
        .Pslverr (pslverr1)
    );

    apb_slave_regs #(.WAIT_CYCLES(0)) dut0 (
        .Hclk    (Hclk),
        .Hreset  (Hreset),
        .Psel    (psel0),
        .Penable (penable0),
        .Pwrite  (pwrite),
        .Paddr   (paddr),
        .PWdata  (pwdata),
        .PRdata  (prdata0),
        .Pready  (pready0),
        .Pslverr (pslverr0)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // One full APB transfer; the expected response is queued at setup and
    // popped when the selected completer raises Pready.
    task automatic applyStimulus(input logic wr, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] exp_data,
                                 input logic exp_err, input string tag);
        exp_t e;
        int   cycles;
        bit   done;
        e.data    = (wr || exp_err) ? 32'h0 : exp_data;
        e.err     = exp_err;
        e.latency = (tgt == 1) ? 2 : 1;
        e.tag     = tag;
        sb.push_back(e);
        @(posedge Hclk) #1;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
        @(posedge Hclk) #1;
        penable = 1'b1;
        cycles = 0;
        done   = 1'b0;
        while (!done && cycles < 20) begin
            @(negedge Hclk);
            cycles++;
            if (pready) done = 1'b1;
        end
        e = sb.pop_front();
        if (!done) begin
            checkOutput({e.tag, " timeout"}, {31'b0, pready}, 32'h1);
        end else begin
            checkOutput({e.tag, " rdata"}, prdata, e.data);
            checkOutput({e.tag, " slverr"}, {31'b0, pslverr}, {31'b0, e.err});
            checkOutput({e.tag, " latency"}, 32'(cycles), 32'(e.latency));
        end
    endtask

    task automatic idleCycles(input int n);
        @(posedge Hclk) #1;
        psel = 1'b0; penable = 1'b0;
        repeat (n - 1) @(posedge Hclk);
    endtask

    task automatic protocolError();
        @(posedge Hclk) #1;
        psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 32'h0;
        @(negedge Hclk);
        checkOutput("abort pready", {31'b0, pready}, 32'h0);
        @(posedge Hclk) #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    initial begin
        tgt = 1;
        Hreset = 1'b1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
        repeat (2) @(posedge Hclk);
        @(negedge Hclk);
        checkOutput("reset prdata", prdata, 32'h0);
        checkOutput("reset pready", {31'b0, pready}, 32'h0);
        checkOutput("reset pslverr", {31'b0, pslverr}, 32'h0);
        @(posedge Hclk) #1;
        Hreset = 1'b0;

        applyStimulus(1'b0, 32'h00, 32'h0, 32'h0, 1'b0, "rd00 after reset");
        applyStimulus(1'b1, 32'h08, 32'hDEAD_BEEF, 32'h0, 1'b0, "wr08");
        applyStimulus(1'b0, 32'h08, 32'h0, 32'hDEAD_BEEF, 1'b0, "rd08");
        idleCycles(2);

        tgt = 0;
        applyStimulus(1'b0, 32'h3C, 32'h0, 32'hA5B0_0001, 1'b0, "zero-wait rdID");
        idleCycles(1);
        tgt = 1;

        applyStimulus(1'b1, 32'h3C, 32'h1234_0000, 32'h0, 1'b1, "wrID err");
        applyStimulus(1'b1, 32'h0A, 32'h5555_5555, 32'h0, 1'b1, "wr0A err");
        applyStimulus(1'b1, 32'h40, 32'h6666_6666, 32'h0, 1'b1, "wr40 err");
        applyStimulus(1'b0, 32'h3C, 32'h0, 32'hA5B0_0001, 1'b0, "rdID kept");
        applyStimulus(1'b0, 32'h08, 32'h0, 32'hDEAD_BEEF, 1'b0, "rd08 kept");
        applyStimulus(1'b0, 32'h00, 32'h0, 32'h0, 1'b0, "rd00 kept");
        applyStimulus(1'b0, 32'h41, 32'h0, 32'h0, 1'b1, "rd41 err");
        idleCycles(1);

        applyStimulus(1'b1, 32'h00, 32'h1234_5678, 32'h0, 1'b0, "b2b wr00");
        applyStimulus(1'b0, 32'h00, 32'h0, 32'h1234_5678, 1'b0, "b2b rd00");
        idleCycles(1);

        applyStimulus(1'b1, 32'h04, 32'h1111_1111, 32'h0, 1'b0, "wr04");
        idleCycles(1);
        @(posedge Hclk) #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h04; pwdata = 32'h2222_2222;
        @(posedge Hclk) #1;
        penable = 1'b1;
        @(negedge Hclk);
        checkOutput("wait pready", {31'b0, pready}, 32'h0);
        @(posedge Hclk) #1;
        psel = 1'b0; penable = 1'b0;
        idleCycles(1);
        applyStimulus(1'b0, 32'h04, 32'h0, 32'h1111_1111, 1'b0, "rd04 after abort");
        applyStimulus(1'b0, 32'h38, 32'h0, 32'h0, 1'b0, "status after psel abort");
        idleCycles(1);

        @(posedge Hclk) #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h08;
        @(posedge Hclk) #1;
        penable = 1'b1;
        Hreset  = 1'b1;
        @(posedge Hclk) #1;
        Hreset = 1'b0; psel = 1'b0; penable = 1'b0;
        @(negedge Hclk);
        checkOutput("midreset prdata", prdata, 32'h0);
        checkOutput("midreset pready", {31'b0, pready}, 32'h0);
        checkOutput("midreset pslverr", {31'b0, pslverr}, 32'h0);
        applyStimulus(1'b0, 32'h08, 32'h0, 32'h0, 1'b0, "rd08 after reset");
        idleCycles(1);

        for (int i = 0; i < 3; i++) begin
            protocolError();
        end
        idleCycles(1);
        applyStimulus(1'b0, 32'h38, 32'h0, 32'h3, 1'b0, "status count");
        applyStimulus(1'b1, 32'h38, 32'hFFFF_FFFF, 32'h0, 1'b0, "status clear");
        applyStimulus(1'b0, 32'h38, 32'h0, 32'h0, 1'b0, "status cleared");
        idleCycles(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/apb_slave_regs.md
APB_SLAVE_REGS -- requirements
Module: apb_slave_regs

Interface
REQ-001 Parameter WAIT_CYCLES, default 1: access-phase wait states inserted before Pready (0..15).
REQ-002 Parameter ID_VALUE, default 32'hA5B0_0001: constant returned by the ID register.
REQ-003 Hclk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Hreset  input  1  reset, synchronous, active-high.
REQ-005 Psel  input  1  completer select, driven from one bit of the bridge's Pselx.
REQ-006 Penable  input  1  APB access-phase indicator.
REQ-007 Pwrite  input  1  1 = write, 0 = read.
REQ-008 Paddr  input  32  byte address.
REQ-009 PWdata  input  32  write data.
REQ-010 PRdata  output  32  read data.
REQ-011 Pready  output  1  transfer completion.
REQ-012 Pslverr  output  1  transfer error; valid only while Pready=1.

Function
REQ-013 The FSM SHALL have three states: ST_IDLE, ST_ACCESS, ST_ABORT.
REQ-014 In ST_IDLE, Psel=1 with Penable=0 (setup) SHALL capture Paddr, Pwrite and PWdata, load the wait counter with WAIT_CYCLES, and move to ST_ACCESS.
REQ-015 In ST_ACCESS with Psel=1 and Penable=1, a nonzero counter SHALL decrement with Pready=0.
REQ-016 In ST_ACCESS with a zero counter, Pready SHALL be 1 for exactly that cycle, the transfer SHALL commit on that edge, and the FSM SHALL return to ST_IDLE.
REQ-017 Latency SHALL be WAIT_CYCLES+1 access-phase cycles; WAIT_CYCLES=0 gives zero-wait completion in the first access cycle.
REQ-018 Decode SHALL be as follows:
- index = captured Paddr[5:2]
- indices 0..13: read/write data registers
- index 14: STATUS; bits [7:0] hold the protocol-error count, upper bits read 0; any write clears the count
- index 15: ID, read-only, returns ID_VALUE
REQ-019 Pslverr SHALL equal 1 with Pready, with no register change, when the captured address has Paddr[1:0]!=0, has Paddr[31:6]!=0, or is a write to index 15.
REQ-020 PRdata SHALL carry the decoded register only while Pready=1 and the captured Pwrite=0, and SHALL be 0 in every other cycle, including error reads.
REQ-021 Pready and Pslverr SHALL be 0 in ST_IDLE and ST_ABORT.
REQ-022 Psel falling to 0 in ST_ACCESS before completion SHALL abort the transfer with no write, and the FSM SHALL move to ST_IDLE.
REQ-023 Penable=1 in ST_IDLE, or Penable=0 with Psel=1 in ST_ACCESS, is a protocol error: the FSM SHALL move to ST_ABORT with no commit.
REQ-024 ST_ABORT SHALL return to ST_IDLE once Psel=0 or Penable=0.
REQ-025 Each entry into ST_ABORT SHALL increment the STATUS error count, saturating at 255.
REQ-026 If a STATUS-clear write and an error increment coincide, the clear SHALL win.
REQ-027 Back-to-back transfers SHALL be supported: a setup phase in the cycle after completion is accepted from ST_IDLE with no idle gap inserted.

Reset
REQ-028 While Hreset=1 the block SHALL, at the next edge:
- force ST_IDLE
- set the wait counter to 0
- clear all data registers and the error count to 0
- drive PRdata=0, Pready=0, Pslverr=0
REQ-029 Hreset asserted mid-transfer SHALL discard the transfer without committing it.

Structure
REQ-030 A shared package apb_pkg SHALL hold:
- the state encoding
- register index constants (STATUS=14, ID=15)
- the address-decode width
- the error-count width
REQ-031 The wait-state down-counter SHALL be the sub-module apb_wait_timer, with load, decrement and zero-flag ports.

Verification
REQ-032 Write 32'hDEAD_BEEF to 0x08, then read 0x08 (WAIT_CYCLES=1) -> PRdata=32'hDEAD_BEEF with Pready=1 on the 2nd access cycle, Pslverr=0.
REQ-033 WAIT_CYCLES=0: read 0x3C -> Pready=1 on the 1st access cycle, PRdata=32'hA5B0_0001.
REQ-034 Write 0x3C, then write 0x0A, then write 0x40 -> Pslverr=1 each time; subsequent reads of 0x3C, 0x08 and 0x00 are unchanged.
REQ-035 Penable=1 without a setup phase, 3 times, then read 0x38 -> PRdata=32'h3.
REQ-036 Check abort and reset behaviour:
- Psel dropped during a wait-state write to 0x04 -> register 1 keeps its old value.
- Hreset pulsed mid-access -> all outputs 0 next cycle.
REQ-037 Back-to-back write 0x00, then read 0x00, with no idle gap -> both complete; the read returns the written data.
